// File: rtl/data_alter_queued.sv
// Queued data-alter block: buffers slave words and button captures, optionally
// alters slave words after a programmable delay, then issues them as master writes.
module data_alter_queued #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DELAY_COUNT = 20,
  parameter int unsigned STEP        = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mode_switch,
  input  logic [1:0]                      op_mode,
  input  logic                            button,
  input  logic [DATA_WIDTH-1:0]           sw_array_data,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_write_en_in,
  input  logic                            m_tx_done,
  output logic [DATA_WIDTH-1:0]           m_data_out,
  output logic [1:0]                      m_instruction,
  output logic [DATA_WIDTH-1:0]           display_data,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_WIDTH + 1;
  localparam int unsigned DW = (DELAY_COUNT > 1) ? $clog2(DELAY_COUNT) : 1;

  localparam logic [DW-1:0]         DLY_LAST    = DW'(DELAY_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] STEP_V      = DATA_WIDTH'(STEP);
  localparam logic [CW-1:0]         FULL_CNT    = CW'(FIFO_DEPTH);
  localparam logic [1:0]            INSTR_IDLE  = 2'b00;
  localparam logic [1:0]            INSTR_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic [1:0]            m_instr_d;
  logic [DATA_WIDTH-1:0] display_d;
  logic [DATA_WIDTH-1:0] alu;

  logic                  button_q;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  btn_edge;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [EW-1:0]         head;
  logic [EW-1:0]         push_data;
  logic                  slv_push, btn_push, push_req, push_ok, full, pop;

  // Button rising edge and the single-entry holding register in front of the queue
  assign btn_edge = button & ~button_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      button_q  <= 1'b0;
      pending_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      button_q <= button;
      if (btn_edge && mode_switch) begin
        pending_q <= 1'b1;
        hold_q    <= sw_array_data;
      end else if (btn_push) begin
        pending_q <= 1'b0;
      end
    end
  end

  // One push per cycle: slave strobe wins, a pending button word waits behind it
  assign slv_push  = s_write_en_in & mode_switch;
  assign btn_push  = mode_switch & ~s_write_en_in & pending_q;
  assign push_req  = slv_push | btn_push;
  assign push_data = slv_push ? {1'b1, s_data} : {1'b0, hold_q};
  assign full      = (fifo_count == FULL_CNT);
  assign push_ok   = push_req & (~full | pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Selected operation on the work register
  always_comb begin
    alu = work_q;
    case (op_mode)
      2'b01:   alu = work_q + STEP_V;
      2'b10:   alu = work_q - STEP_V;
      2'b11:   alu = ~work_q;
      default: alu = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      work_q        <= '0;
      cnt_q         <= '0;
      m_data_out    <= '0;
      m_instruction <= INSTR_IDLE;
      display_data  <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      m_data_out    <= m_data_d;
      m_instruction <= m_instr_d;
      display_data  <= display_d;
      busy          <= (state_d != IDLE);
    end
  end

  // Transaction sequencing: pop, optional delayed alteration, master write handshake
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_out;
    m_instr_d = m_instruction;
    display_d = display_data;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        m_instr_d = INSTR_IDLE;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          work_d    = head[DATA_WIDTH-1:0];
          display_d = head[DATA_WIDTH-1:0];
          cnt_d     = '0;
          if (head[DATA_WIDTH] && (op_mode != 2'b00)) state_d = DELAY;
          else                                        state_d = SEND;
        end
      end
      DELAY: begin
        if (cnt_q == DLY_LAST) begin
          work_d    = alu;
          display_d = alu;
          cnt_d     = '0;
          state_d   = SEND;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      SEND: begin
        m_data_d  = work_q;
        m_instr_d = INSTR_WRITE;
        // Completion only counts once the request is actually on the bus
        if ((m_instruction == INSTR_WRITE) && m_tx_done) begin
          m_instr_d = INSTR_IDLE;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        m_instr_d = INSTR_IDLE;
      end
    endcase
  end

endmodule

// File: doc/data_alter_queued.md
Name: data_alter_queued

Overview:
- Parametrised successor to the single-shot data-alter block. Sits between the bridge slave port (inbound data), the board switches/button, and the bridge master port (outbound data).
- Inbound words and button captures are queued in a small FIFO. Each word is popped and, for slave-sourced words, passed through a selectable ALU op after a programmable delay. The result is then sent out via the master instruction handshake.
- Adds configurable width, FIFO depth, arithmetic mode, button edge detection, an overflow flag and status outputs.

Parameters:
- DATA_WIDTH, 8, width of all data paths.
- DELAY_COUNT, 20, cycles spent in DELAY before the op is applied; must be >= 1.
- STEP, 1, operand for the add/sub modes; truncated to DATA_WIDTH.
- FIFO_DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- mode_switch  in  1  1 = accept new pushes; 0 = ignore inbound data.
- op_mode  in  2  00 pass, 01 add STEP, 10 subtract STEP, 11 bitwise invert.
- button  in  1  level input; only a rising edge is acted on.
- sw_array_data  in  DATA_WIDTH  switch data, captured on the button edge.
- s_data  in  DATA_WIDTH  slave receive data.
- s_write_en_in  in  1  one-cycle strobe; s_data is valid in that cycle.
- m_tx_done  in  1  master transfer complete.
- m_data_out  out  DATA_WIDTH  word presented to the master.
- m_instruction  out  2  00 idle, 10 write request.
- display_data  out  DATA_WIDTH  current work-register value.
- busy  out  1  1 whenever state != IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of occupied entries.
- overflow  out  1  sticky flag: a push was dropped because the FIFO was full.

Behaviour:
- Reset, sampled on clk while reset==0:
  - state=IDLE; FIFO emptied; fifo_count=0; overflow=0; button_pending=0.
  - m_data_out=0; m_instruction=00; display_data=0; busy=0; delay counter=0.
  - Reset asserted mid-transaction aborts it; m_instruction=00 on the next edge.
- Button: registered previous level; rising edge = button & ~button_q.
  - On an edge with mode_switch=1, set button_pending and capture sw_array_data into a holding register.
  - A new edge while pending overwrites the holding register.
- FIFO entry = {src, data}, where src 1=slave, 0=switch. At most one push per cycle.
  - Priority: s_write_en_in & mode_switch pushes s_data with src=1.
  - Otherwise button_pending pushes the held data with src=0 and clears pending.
  - A pending button word waits while slave writes occur in consecutive cycles.
- mode_switch=0: slave strobes and button edges are ignored and do not set overflow. The FIFO contents and any in-flight transaction are unaffected.
- Full condition: a push with fifo_count==FIFO_DEPTH and no same-cycle pop is dropped and sets overflow. A push in the same cycle as a pop while full is accepted. overflow clears only on reset.
- fifo_count updates on the edge after a push or pop (+1, -1, or unchanged if both).
- FSM states:
  - IDLE: m_instruction=00. If fifo_count!=0, pop the head into work and set display_data to the head data.
    - Go to DELAY if src=1 and op_mode!=00; otherwise go to SEND.
  - DELAY: counter runs 0..DELAY_COUNT-1.
    - In the cycle the counter equals DELAY_COUNT-1, apply the op to work and go to SEND.
    - op_mode is sampled in that cycle.
    - add/sub wrap modulo 2^DATA_WIDTH; invert = ~work.
    - display_data follows work.
  - SEND: m_data_out=work and m_instruction=10 are registered on the first cycle and held.
    - When m_tx_done=1, m_instruction=00 on the next edge and state goes to IDLE.
    - m_data_out holds its last value after the transaction.
    - m_tx_done outside SEND is ignored.
- Switch-sourced words (src=0) are sent unaltered and skip DELAY.
- Latency: a slave strobe at edge N with an empty FIFO and IDLE state gives pop at N+1 and m_instruction=10 at N+DELAY_COUNT+2.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 and state IDLE. Strobe s_data=8'h3A with op_mode=01, DELAY_COUNT=4 -> after 4 DELAY cycles m_data_out=8'h3B and m_instruction=10. m_tx_done pulse -> m_instruction=00 next cycle.
- s_data=8'hFF with op_mode=01 -> m_data_out=8'h00 (wrap). s_data=8'h00 with op_mode=10 -> 8'hFF. s_data=8'h5A with op_mode=11 -> 8'hA5.
- Button held high 10 cycles, sw_array_data=8'h77 -> exactly one transaction, with m_data_out=8'h77, no DELAY, regardless of op_mode.
- With m_tx_done held low, issue 5 slave strobes (FIFO_DEPTH=4, one word popped into work) -> fifo_count=4 and overflow=0. A 6th strobe -> dropped and overflow=1. Release m_tx_done -> 5 words sent in order.
- Slave strobe and button edge in the same cycle -> slave word queued first, button word on the next cycle; both sent in that order.
- mode_switch=0 with strobes and button edges -> no pushes and overflow stays 0. Reset asserted during SEND -> m_instruction=00, fifo_count=0 on the next edge.
